// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: redirect/hint inputs from decode/execute and
// the fetch address outputs toward instruction memory.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_req;
  logic            halt_req;
  logic            call_hint;
  logic            ret_hint;
  logic [XLEN-1:0] pc_current;
  logic [XLEN-1:0] pc_next;
  logic            fetch_valid;
  logic            halted;
  logic            misaligned_err;
  logic            ras_empty;

  modport master (
    output stall, redirect_valid, redirect_target, trap_req, halt_req,
           call_hint, ret_hint,
    input  pc_current, pc_next, fetch_valid, halted, misaligned_err, ras_empty
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_req, halt_req,
           call_hint, ret_hint,
    output pc_current, pc_next, fetch_valid, halted, misaligned_err, ras_empty
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT control, trap/redirect vectoring,
// misalignment trapping. Define PC_RAS_EN to add the return-address stack.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            halted_q, halted_d;
  logic            misaligned_err_q, misaligned_err_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_bad;
  logic [XLEN-1:0] redir_pc;
  logic            hint_ok;
  logic            ras_hit;
  logic [XLEN-1:0] ras_top;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign redir_tgt = {bus.redirect_target[XLEN-1:1], 1'b0};
  assign redir_bad = redir_tgt[1];
  assign redir_pc  = redir_bad ? TRAP_VECTOR : redir_tgt;

  // A halting fetch is not consumed, so its hints are dropped as well.
  assign hint_ok = (state_q == RUN) && !bus.trap_req && !bus.redirect_valid &&
                   !bus.halt_req && !bus.stall;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    misaligned_err_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.trap_req) begin
          pc_d = TRAP_VECTOR;
        end else if (bus.redirect_valid) begin
          pc_d             = redir_pc;
          misaligned_err_d = redir_bad;
        end else if (bus.halt_req) begin
          state_d = HALT;
        end else if (ras_hit) begin
          pc_d = ras_top;
        end else if (!bus.stall) begin
          pc_d = pc_plus4;
        end
      end
      HALT: begin
        if (bus.trap_req) begin
          pc_d    = TRAP_VECTOR;
          state_d = RUN;
        end else if (bus.redirect_valid) begin
          pc_d             = redir_pc;
          misaligned_err_d = redir_bad;
          state_d          = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    fetch_valid_d = (state_d == RUN);
    halted_d      = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= BOOT;
      pc_q             <= RESET_VECTOR;
      fetch_valid_q    <= 1'b0;
      halted_q         <= 1'b0;
      misaligned_err_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      fetch_valid_q    <= fetch_valid_d;
      halted_q         <= halted_d;
      misaligned_err_q <= misaligned_err_d;
    end
  end

  assign bus.pc_current     = pc_q;
  assign bus.pc_next        = pc_d;
  assign bus.fetch_valid    = fetch_valid_q;
  assign bus.halted         = halted_q;
  assign bus.misaligned_err = misaligned_err_q;

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [XLEN-1:0]  ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign pop     = hint_ok && bus.ret_hint && (cnt_q != '0);
  assign push    = hint_ok && bus.call_hint;
  assign ras_hit = pop;
  assign ras_top = ras_q[sp_q];

  // sp points at the top entry; a push on a full stack wraps onto the oldest.
  always_comb begin
    ras_d = ras_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (pop && push) begin
      ras_d[sp_q] = pc_plus4;
    end else if (push) begin
      sp_d        = sp_q + PTR_W'(1);
      ras_d[sp_d] = pc_plus4;
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      ras_q <= ras_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ras_empty = (cnt_q == '0);
`else
  localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
  logic unused_hints;

  assign unused_hints  = bus.call_hint ^ bus.ret_hint ^ hint_ok;
  assign ras_hit       = 1'b0;
  assign ras_top       = '0;
  assign bus.ras_empty = 1'b1;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen: a 32-bit instance for the main behaviour
// and a 16-bit instance for address wrap. RAS vectors run when PC_RAS_EN is set.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) a ();
  pc_gen_if #(.XLEN(16)) b ();

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .RAS_DEPTH(4))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(a));

  pc_gen #(.XLEN(16), .RESET_VECTOR(16'h0), .TRAP_VECTOR(16'h100), .RAS_DEPTH(4))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    a.stall = 0; a.redirect_valid = 0; a.redirect_target = '0; a.trap_req = 0;
    a.halt_req = 0; a.call_hint = 0; a.ret_hint = 0;
  endtask

  task automatic redirect_a(input logic [31:0] tgt);
    a.redirect_valid = 1; a.redirect_target = tgt;
    tick();
    a.redirect_valid = 0;
  endtask

  task automatic boot_sequence(input string pfx);
    chk({pfx, "_boot_pc"}, a.pc_current, 32'h0);
    chk({pfx, "_boot_fv"}, {31'b0, a.fetch_valid}, 32'h0);
    tick(); chk({pfx, "_pc0"}, a.pc_current, 32'h0);
    chk({pfx, "_fv1"}, {31'b0, a.fetch_valid}, 32'h1);
    tick(); chk({pfx, "_pc4"}, a.pc_current, 32'h4);
    tick(); chk({pfx, "_pc8"}, a.pc_current, 32'h8);
    tick(); chk({pfx, "_pcC"}, a.pc_current, 32'hC);
  endtask

  initial begin
    clear_a();
    b.stall = 0; b.redirect_valid = 0; b.redirect_target = '0; b.trap_req = 0;
    b.halt_req = 0; b.call_hint = 0; b.ret_hint = 0;
    tick(); tick();
    chk("rst_pc", a.pc_current, 32'h0);
    chk("rst_fv", {31'b0, a.fetch_valid}, 32'h0);
    chk("rst_halted", {31'b0, a.halted}, 32'h0);
    chk("rst_mis", {31'b0, a.misaligned_err}, 32'h0);
    chk("rst_ras_empty", {31'b0, a.ras_empty}, 32'h1);

    // Reset release and free-running increment; stop at pc_current=8.
    rst_n = 1;
    chk("boot_pc", a.pc_current, 32'h0);
    chk("boot_fv", {31'b0, a.fetch_valid}, 32'h0);
    tick(); chk("run_pc0", a.pc_current, 32'h0);
    chk("run_fv", {31'b0, a.fetch_valid}, 32'h1);
    tick(); chk("run_pc4", a.pc_current, 32'h4);
    tick(); chk("run_pc8", a.pc_current, 32'h8);

    // Stall three cycles at 8.
    a.stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_pc_next", a.pc_next, 32'h8);
      tick(); chk("stall_pc", a.pc_current, 32'h8);
    end
    a.stall = 0;
    #1 chk("unstall_pc_next", a.pc_next, 32'hC);
    tick(); chk("unstall_pc", a.pc_current, 32'hC);

    // Redirect overrides stall.
    a.stall = 1; a.redirect_valid = 1; a.redirect_target = 32'h40;
    #1 chk("stall_redir_pc_next", a.pc_next, 32'h40);
    tick(); chk("stall_redir_pc", a.pc_current, 32'h40);
    clear_a();

    // Misaligned redirect vectors to trap with a one-cycle error pulse.
    a.redirect_valid = 1; a.redirect_target = 32'h42;
    #1 chk("mis_pc_next", a.pc_next, 32'h100);
    tick(); chk("mis_pc", a.pc_current, 32'h100);
    chk("mis_err_hi", {31'b0, a.misaligned_err}, 32'h1);
    a.redirect_valid = 0;
    tick(); chk("mis_pc_after", a.pc_current, 32'h104);
    chk("mis_err_lo", {31'b0, a.misaligned_err}, 32'h0);

    // Bit 0 is simply cleared.
    redirect_a(32'h41);
    chk("odd_redir_pc", a.pc_current, 32'h40);
    chk("odd_redir_err", {31'b0, a.misaligned_err}, 32'h0);

    // Halt at 0x10; stall and halt_req are ignored while halted.
    redirect_a(32'h10);
    chk("pre_halt_pc", a.pc_current, 32'h10);
    a.halt_req = 1;
    #1 chk("halt_pc_next", a.pc_next, 32'h10);
    tick();
    a.stall = 1;
    for (int i = 0; i < 5; i++) begin
      chk("halt_pc", a.pc_current, 32'h10);
      chk("halt_halted", {31'b0, a.halted}, 32'h1);
      chk("halt_fv", {31'b0, a.fetch_valid}, 32'h0);
      tick();
    end
    chk("halt_hold_next", a.pc_next, 32'h10);
    a.halt_req = 0; a.stall = 0; a.trap_req = 1;
    #1 chk("halt_trap_next", a.pc_next, 32'h100);
    tick(); chk("halt_trap_pc", a.pc_current, 32'h100);
    chk("halt_trap_run", {31'b0, a.fetch_valid}, 32'h1);
    chk("halt_trap_halted", {31'b0, a.halted}, 32'h0);
    a.trap_req = 0;
    tick(); chk("post_trap_pc", a.pc_current, 32'h104);

    // 16-bit wrap.
    b.redirect_valid = 1; b.redirect_target = 16'hFFFC;
    tick(); b.redirect_valid = 0;
    chk("x16_pc", {16'b0, b.pc_current}, 32'hFFFC);
    #1 chk("x16_wrap_next", {16'b0, b.pc_next}, 32'h0);
    tick(); chk("x16_wrap_pc", {16'b0, b.pc_current}, 32'h0);

`ifdef PC_RAS_EN
    // Single call/return pair.
    redirect_a(32'h20);
    a.call_hint = 1;
    tick(); a.call_hint = 0;
    chk("ras_call_pc", a.pc_current, 32'h24);
    chk("ras_not_empty", {31'b0, a.ras_empty}, 32'h0);
    redirect_a(32'h80);
    a.ret_hint = 1;
    #1 chk("ras_ret_next", a.pc_next, 32'h24);
    tick(); a.ret_hint = 0;
    chk("ras_ret_pc", a.pc_current, 32'h24);
    chk("ras_empty_again", {31'b0, a.ras_empty}, 32'h1);

    // Five calls overflow a 4-deep stack; the oldest (0x204) is lost.
    redirect_a(32'h200);
    a.call_hint = 1;
    for (int i = 0; i < 5; i++) tick();
    a.call_hint = 0;
    chk("ras5_pc", a.pc_current, 32'h214);
    a.ret_hint = 1;
    #1 chk("ras5_ret1", a.pc_next, 32'h214);
    tick(); #1 chk("ras5_ret2", a.pc_next, 32'h210);
    tick(); #1 chk("ras5_ret3", a.pc_next, 32'h20C);
    tick(); #1 chk("ras5_ret4", a.pc_next, 32'h208);
    tick();
    chk("ras5_empty", {31'b0, a.ras_empty}, 32'h1);
    #1 chk("ras5_ret5", a.pc_next, 32'h20C);
    tick(); a.ret_hint = 0;
    chk("ras5_fall_pc", a.pc_current, 32'h20C);
`endif

    // Asynchronous reset while a redirect is in flight.
    redirect_a(32'h40);
    a.redirect_valid = 1; a.redirect_target = 32'h80;
    #2 rst_n = 0;
    #1 chk("mid_rst_pc", a.pc_current, 32'h0);
    chk("mid_rst_fv", {31'b0, a.fetch_valid}, 32'h0);
    chk("mid_rst_mis", {31'b0, a.misaligned_err}, 32'h0);
    chk("mid_rst_ras", {31'b0, a.ras_empty}, 32'h1);
    clear_a();
    tick();
    rst_n = 1;
    boot_sequence("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V core's fetch stage, successor to the fixed 32-bit increment-only PC. It owns the architectural PC register, computes the next fetch address, and adds stall, branch/jump redirect, trap vectoring, halt, misalignment detection and an optional return-address stack. It sits between the instruction memory address port and the decode/execute stages, which supply redirect and hint signals.

## Interface
- XLEN, 32: PC width in bits, minimum 16.
- RESET_VECTOR, 0: PC value loaded on reset, 4-byte aligned.
- TRAP_VECTOR, 'h100: PC value loaded on trap or misaligned redirect, 4-byte aligned.
- RAS_DEPTH, 4: return-address stack entries, power of two from 2 to 16; used only with PC_RAS_EN.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC; the fetch is not consumed.
- redirect_valid  in  1  taken branch/jump or mispredict correction from execute.
- redirect_target  in  XLEN  target address for the redirect.
- trap_req  in  1  exception/ecall; vector to TRAP_VECTOR.
- halt_req  in  1  stop fetching; honoured in RUN only.
- call_hint  in  1  instruction at pc_current is a call (jal/jalr writing x1/x5).
- ret_hint  in  1  instruction at pc_current is a return (jalr x0, 0(x1/x5)).
- pc_current  out  XLEN  registered fetch address.
- pc_next  out  XLEN  combinational address to be loaded at the next edge.
- fetch_valid  out  1  pc_current is a valid fetch address.
- halted  out  1  unit is in HALT.
- misaligned_err  out  1  one-cycle registered pulse when a misaligned redirect was converted to a trap.
- ras_empty  out  1  RAS holds no entries.

## Operation
- States: BOOT, RUN, HALT.
- BOOT: entered on reset. pc_current=RESET_VECTOR, fetch_valid=0. Unconditionally -> RUN at the next edge, with the PC unchanged. The first fetch is RESET_VECTOR.
- RUN: fetch_valid=1. pc_next priority, highest first:
  - trap_req -> TRAP_VECTOR.
  - redirect_valid -> redirect_target with bit0 cleared. If bit1 is then 1, the target is misaligned: use TRAP_VECTOR and pulse misaligned_err next cycle.
  - RAS prediction: ret_hint with RAS non-empty -> top entry.
  - stall -> pc_current.
  - otherwise pc_current+4.
- Trap and redirect override stall. Addition wraps modulo 2^XLEN.
- halt_req in RUN, with no trap or redirect that cycle -> HALT; pc_current holds.
- HALT: fetch_valid=0, halted=1, pc_next=pc_current. trap_req or redirect_valid loads the target by the same rules and -> RUN. halt_req and stall are ignored.
- Reset asserted in any state, mid-stall or mid-redirect: immediately BOOT, pc_current=RESET_VECTOR, misaligned_err=0, RAS cleared.

## Timing
- All outputs except pc_next are registered. Reset values: pc_current=RESET_VECTOR, fetch_valid=0, halted=0, misaligned_err=0, ras_empty=1.
- pc_next is combinational from current-cycle inputs; zero-cycle input-to-pc_next latency, one-cycle latency to pc_current.
- Redirect/trap: target appears on pc_current the edge after assertion, including while stalled.
- misaligned_err is high for exactly the cycle pc_current first equals TRAP_VECTOR.
- Hints are sampled only when fetch_valid=1, stall=0, and neither trap_req nor redirect_valid is asserted.

## Configuration
- PC_RAS_EN defined: RAS of RAS_DEPTH entries.
  - call_hint pushes pc_current+4.
  - ret_hint pops and predicts.
  - Both asserted: pop then push; the top is replaced and the count is unchanged.
  - Push when full overwrites the oldest entry (circular); the count saturates at RAS_DEPTH.
  - ret_hint when empty: no prediction, pc_current+4, no pop.
  - The RAS is not repaired on redirect.
- PC_RAS_EN undefined: no RAS storage. Hints are ignored, ras_empty is tied to 1, and the priority list skips the RAS step. The port list is identical in both builds.

## Test plan
- Reset release, idle inputs: cycle 0 pc_current=0 with fetch_valid=0; then 0, 4, 8, 0xC with fetch_valid=1.
- stall high for 3 cycles at pc_current=8: pc_current stays 8 and pc_next=8; after release pc_current goes to 0xC. redirect_valid to 0x40 during a stall: next edge pc_current=0x40.
- redirect_target=0x42: next edge pc_current=0x100 with misaligned_err=1 for one cycle. redirect_target=0x41: pc_current=0x40 and no error.
- halt_req at pc_current=0x10: halted=1, fetch_valid=0, PC holds for 5 cycles. trap_req then gives pc_current=0x100, RUN. XLEN=16 at 0xFFFC: next PC is 0x0000.
- PC_RAS_EN, RAS_DEPTH=4:
  - call_hint at 0x20 then ret_hint at 0x80: pc_next=0x24.
  - 5 calls then 5 returns: the first 4 predict in LIFO order; the 5th falls through to +4 with ras_empty=1.
- Assert rst_n low mid-redirect at pc_current=0x40: immediately pc_current=0 and fetch_valid=0. Release: same sequence as the first scenario.
